sfifo_param: RTL and testbench

Parametrised single-clock FIFO for the ethaudio datapath, generalising the fixed 25-bit audio sample buffer to any width and power-of-two depth. Adds occupancy count, programmable almost-full/almost-empty flags, and overflow/underflow error pulses. Sits between the Ethernet audio depacketiser and the HDMI audio sample packer where both run on one clock domain. A compile-time option selects first-word-fall-through (FWFT) read behaviour.

---
 rtl/sfifo_param.sv | 93 +++++++++
 tb/tb_sfifo_param.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/sfifo_param.sv
// sfifo_param: parametrised single-clock FIFO with occupancy count, programmable almost flags
// and overflow/underflow pulses. Define SFIFO_FWFT_EN for first-word-fall-through reads.
module sfifo_param #(
    parameter int DATA_WIDTH    = 25,
    parameter int ADDRESS_WIDTH = 4,
    parameter int AFULL_THRESH  = (2 ** ADDRESS_WIDTH) - 2,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH-1:0]   din,
    input  logic                    wr_en,
    input  logic                    rd_en,
    output logic [DATA_WIDTH-1:0]   dout,
    output logic                    full,
    output logic                    empty,
    output logic                    almost_full,
    output logic                    almost_empty,
    output logic [ADDRESS_WIDTH:0]  count,
    output logic                    overflow,
    output logic                    underflow
);

    localparam int DEPTH = 2 ** ADDRESS_WIDTH;
    localparam logic [ADDRESS_WIDTH:0]   DEPTH_C  = (ADDRESS_WIDTH + 1)'(DEPTH);
    localparam logic [ADDRESS_WIDTH:0]   AFULL_C  = (ADDRESS_WIDTH + 1)'(AFULL_THRESH);
    localparam logic [ADDRESS_WIDTH:0]   AEMPTY_C = (ADDRESS_WIDTH + 1)'(AEMPTY_THRESH);
    localparam logic [ADDRESS_WIDTH:0]   CNT_ONE  = (ADDRESS_WIDTH + 1)'(1);
    localparam logic [ADDRESS_WIDTH-1:0] PTR_ONE  = ADDRESS_WIDTH'(1);

    logic [DATA_WIDTH-1:0]    mem [DEPTH];
    logic [ADDRESS_WIDTH-1:0] wr_ptr;
    logic [ADDRESS_WIDTH-1:0] rd_ptr;
    logic [ADDRESS_WIDTH:0]   count_next;
    logic                     wr_acc;
    logic                     rd_acc;

    // Acceptance uses the registered flags, so a full FIFO can still take a write-and-read pair
    // only on the read side.
    always_comb begin
        wr_acc     = wr_en && !full;
        rd_acc     = rd_en && !empty;
        count_next = count;
        case ({wr_acc, rd_acc})
            2'b10:   count_next = count + CNT_ONE;
            2'b01:   count_next = count - CNT_ONE;
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_acc)
            mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (wr_acc)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (rd_acc)
                rd_ptr <= rd_ptr + PTR_ONE;
            count        <= count_next;
            full         <= (count_next == DEPTH_C);
            empty        <= (count_next == '0);
            almost_full  <= (count_next >= AFULL_C);
            almost_empty <= (count_next <= AEMPTY_C);
            overflow     <= wr_en && full;
            underflow    <= rd_en && empty;
        end
    end

`ifdef SFIFO_FWFT_EN
    always_comb dout = mem[rd_ptr];
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            dout <= '0;
        else if (rd_acc)
            dout <= mem[rd_ptr];
    end
`endif

endmodule

// File: tb/tb_sfifo_param.sv
// Scoreboard bench for sfifo_param: driver models occupancy and queues expected read data,
// a separate monitor compares dout whenever an accepted read presents its word.
module tb_sfifo_param;

    logic        clk = 1'b0;
    logic        rst;
    logic [24:0] din;
    logic        wr_en, rd_en;
    logic [24:0] dout;
    logic        full, empty, almost_full, almost_empty;
    logic [4:0]  count;
    logic        overflow, underflow;

    int unsigned passed = 0;
    int unsigned total  = 0;

    logic [24:0] model_q[$];
    logic [24:0] sb_q[$];
    int          mcount = 0;
    logic        mon_rd = 1'b0;

    sfifo_param #(
        .DATA_WIDTH   (25),
        .ADDRESS_WIDTH(4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .din         (din),
        .wr_en       (wr_en),
        .rd_en       (rd_en),
        .dout        (dout),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .almost_empty(almost_empty),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp)
            passed++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic chk_flags(input logic eovf, input logic eunf);
        chk("count", 32'(count), 32'(mcount));
        chk("full", 32'(full), 32'(mcount == 16));
        chk("empty", 32'(empty), 32'(mcount == 0));
        chk("almost_full", 32'(almost_full), 32'(mcount >= 14));
        chk("almost_empty", 32'(almost_empty), 32'(mcount <= 2));
        chk("overflow", 32'(overflow), 32'(eovf));
        chk("underflow", 32'(underflow), 32'(eunf));
    endtask

    // One clock of stimulus; called at posedge+1, returns at the following posedge+1.
    task automatic cyc(input logic w, input logic [24:0] d, input logic r);
        logic aw, ar, eovf, eunf;
        aw   = w && (mcount < 16);
        ar   = r && (mcount > 0);
        eovf = w && (mcount == 16);
        eunf = r && (mcount == 0);
        wr_en = w;
        din   = d;
        rd_en = r;
        mon_rd = ar;
        if (ar)
            sb_q.push_back(model_q.pop_front());
        if (aw)
            model_q.push_back(d);
        mcount = mcount + (aw ? 1 : 0) - (ar ? 1 : 0);
        @(posedge clk);
        #1;
        wr_en  = 1'b0;
        rd_en  = 1'b0;
        mon_rd = 1'b0;
        chk_flags(eovf, eunf);
    endtask

    // Monitor: standard mode presents the word after the read edge, FWFT before it.
    initial begin
`ifdef SFIFO_FWFT_EN
        forever begin
            @(negedge clk);
            if (mon_rd) begin
                if (sb_q.size() == 0) chk("sb_underrun", 32'd1, 32'd0);
                else chk("dout", 32'(dout), 32'(sb_q.pop_front()));
            end
        end
`else
        forever begin
            @(posedge clk);
            if (mon_rd) begin
                #1;
                if (sb_q.size() == 0) chk("sb_underrun", 32'd1, 32'd0);
                else chk("dout", 32'(dout), 32'(sb_q.pop_front()));
            end
        end
`endif
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; din = '0; wr_en = 1'b0; rd_en = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        chk_flags(1'b0, 1'b0);
`ifndef SFIFO_FWFT_EN
        chk("reset_dout", 32'(dout), 32'h0);
`endif

        // Fill to 16, then one rejected write
        for (int i = 1; i <= 16; i++) begin
            cyc(1'b1, 25'(i), 1'b0);
`ifdef SFIFO_FWFT_EN
            if (i == 1) chk("fwft_first", 32'(dout), 32'h1);
`endif
        end
        cyc(1'b1, 25'h1FFFFFF, 1'b0);
        cyc(1'b0, '0, 1'b0);

        // Drain 16, then one rejected read
        for (int i = 1; i <= 16; i++) cyc(1'b0, '0, 1'b1);
        cyc(1'b0, '0, 1'b1);
`ifndef SFIFO_FWFT_EN
        chk("dout_hold", 32'(dout), 32'h10);
`endif
        cyc(1'b0, '0, 1'b0);

        // Simultaneous read/write when full, then when empty
        for (int i = 0; i < 16; i++) cyc(1'b1, 25'h20 + 25'(i), 1'b0);
        cyc(1'b1, 25'h0AAAAAA, 1'b1);
        for (int i = 0; i < 15; i++) cyc(1'b0, '0, 1'b1);
        cyc(1'b1, 25'h0155555, 1'b1);
        cyc(1'b0, '0, 1'b1);

        // Sustained throughput across pointer wrap
        for (int i = 0; i < 3; i++) cyc(1'b1, 25'h100 + 25'(i), 1'b0);
        for (int i = 0; i < 40; i++) cyc(1'b1, 25'h200 + 25'(i), 1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b1);

        // Asynchronous reset mid-burst at count 9
        for (int i = 0; i < 9; i++) cyc(1'b1, 25'h300 + 25'(i), 1'b0);
        #2 rst = 1'b1;
        #1;
        model_q.delete();
        mcount = 0;
        chk_flags(1'b0, 1'b0);
`ifndef SFIFO_FWFT_EN
        chk("async_rst_dout", 32'(dout), 32'h0);
`endif
        @(posedge clk); #1 rst = 1'b0;
        cyc(1'b1, 25'h1ABCDEF, 1'b0);
        cyc(1'b0, '0, 1'b1);
        cyc(1'b0, '0, 1'b0);
        cyc(1'b0, '0, 1'b0);

        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
